rx_frame_collect: RTL and testbench
===================================

// Module: rx_frame_collect
// PURPOSE
//  Downstream of the FFT serial-to-parallel stage; consumes its 8 per-bin registers and one-hot bin strobe.
//  Assembles a complete 8-bin receive symbol, checks bin order and duplicates, then hands the symbol
//  to the demodulator through a valid/ready register slice (working buffer + output buffer).
// PARAMETERS
//  DW          20  signed width of each real/imag sample
//  NBIN        8   bins per symbol (must match one-hot strobe width)
//  ORDERED     1   1: bins must arrive 0..NBIN-1 ascending; 0: any order, duplicates flagged
//  TIMEOUT_CYC 64  idle cycles in COLLECT before partial frame is dropped (FRAME_TIMEOUT_EN only)
// PORTS
//  clk              in   1          system clock
//  rstn             in   1          async active-low reset
//  receive_sig_real in   NBIN*DW    per-bin real samples, packed [NBIN-1:0][DW-1:0], signed
//  receive_sig_imag in   NBIN*DW    per-bin imag samples, same packing
//  Rx_tvalid        in   NBIN       one-hot: bit k = bin k register updated this cycle
//  frame_ready      in   1          consumer accepts frame when frame_valid&frame_ready
//  frame_real       out  NBIN*DW    assembled symbol real parts
//  frame_imag       out  NBIN*DW    assembled symbol imag parts
//  frame_valid      out  1          output buffer holds an unconsumed symbol
//  frame_count      out  16         symbols emitted, wraps 0xFFFF->0
//  err_order        out  1          1-cycle pulse: out-of-order or multi-hot strobe
//  err_dup          out  1          1-cycle pulse: bin received twice in one frame (ORDERED=0)
//  frame_overrun    out  1          1-cycle pulse: completed frame dropped, output still full
//  frame_timeout    out  1          1-cycle pulse: partial frame dropped on timeout
// BEHAVIOUR
//  Reset (async, rstn=0): all outputs 0, mask 0, state IDLE, working/output buffers 0, timeout counter 0.
//  States: IDLE (mask=0) -> COLLECT on first accepted bin; COLLECT -> IDLE on completion/discard.
//  Output buffer is independent: frame_valid set on completion, cleared on valid&ready handshake.
//  Strobe decode: Rx_tvalid=0 -> no action; multi-hot -> err_order pulse, partial discarded, IDLE.
//  Bin k accepted: receive_sig_real[k]/imag[k] sampled in same cycle as Rx_tvalid[k], stored in slot k, mask[k]=1.
//  ORDERED=1: expected index = popcount(mask). k==expected -> accept. k==0 mid-frame -> err_order,
//   drop partial, restart frame with bin 0 accepted. Other k!=expected -> err_order, drop partial, IDLE.
//  ORDERED=0: k already in mask -> err_dup pulse, slot k overwritten, mask unchanged.
//  Completion: cycle n accepts last missing bin -> cycle n+1 frame_valid=1, frame_* = full symbol
//   (latency 1), frame_count+1, mask cleared, IDLE. Bin 0 of next symbol may arrive at n+1.
//  frame_valid stays high with frame_* stable until frame_ready=1; handshake cycle clears it.
//  Completion while frame_valid=1 and frame_ready=0 -> frame_overrun pulse, new symbol dropped,
//   output unchanged, frame_count unchanged. Completion with frame_valid=1 and frame_ready=1 same
//   cycle -> old consumed, new loaded, frame_valid stays 1, no overrun.
//  No arithmetic on samples; widths pass through unchanged, sign preserved.
//  Error pulses may coincide; each asserted for exactly the triggering cycle+1 (registered).
// CONFIGURATION
//  FRAME_TIMEOUT_EN defined: in COLLECT a counter increments each cycle without accepted bin, clears
//   on accepted bin; reaching TIMEOUT_CYC -> frame_timeout pulse, mask cleared, IDLE.
//  FRAME_TIMEOUT_EN undefined: no counter; frame_timeout tied 0; partial frame waits indefinitely.
// TESTING
//  Bins 0..7 on consecutive cycles, real[k]=k+1, imag[k]=-(k+1), ready=1 -> frame_valid 1 cycle after bin 7, values match, frame_count=1.
//  ORDERED=1, bins 0,1,3 -> err_order on bin 3, no frame; then 0..7 -> one clean frame.
//  ORDERED=0, bins 7,6..0 with bin 4 repeated (value 0x7FFFF then 0x80000) -> err_dup once, frame slot4=0x80000.
//  ready=0, two full symbols -> first held stable, frame_overrun on second completion, count=1; ready=1 releases first.
//  Rx_tvalid=8'b00000011 mid-frame -> err_order, partial dropped; rstn low mid-frame -> all outputs 0 immediately.
//  FRAME_TIMEOUT_EN, TIMEOUT_CYC=64: bins 0..2 then 64 idle cycles -> frame_timeout pulse, next bin 0 starts fresh frame.

Source files
------------

// File: rtl/rx_frame_collect_if.sv
// rx_frame_collect_if: per-bin sample bus from the FFT serial-to-parallel stage
// and the assembled-symbol valid/ready bus towards the demodulator.
// The master side is the surrounding system; the slave side is the collector.
interface rx_frame_collect_if #(
  parameter int DW   = 20,
  parameter int NBIN = 8
);
  logic [NBIN-1:0][DW-1:0] receive_sig_real;
  logic [NBIN-1:0][DW-1:0] receive_sig_imag;
  logic [NBIN-1:0]         Rx_tvalid;
  logic                    frame_ready;
  logic [NBIN-1:0][DW-1:0] frame_real;
  logic [NBIN-1:0][DW-1:0] frame_imag;
  logic                    frame_valid;
  logic [15:0]             frame_count;
  logic                    err_order;
  logic                    err_dup;
  logic                    frame_overrun;
  logic                    frame_timeout;

  modport master (
    output receive_sig_real, receive_sig_imag, Rx_tvalid, frame_ready,
    input  frame_real, frame_imag, frame_valid, frame_count,
    input  err_order, err_dup, frame_overrun, frame_timeout
  );

  modport slave (
    input  receive_sig_real, receive_sig_imag, Rx_tvalid, frame_ready,
    output frame_real, frame_imag, frame_valid, frame_count,
    output err_order, err_dup, frame_overrun, frame_timeout
  );
endinterface

// File: rtl/rx_frame_collect.sv
// rx_frame_collect: gathers NBIN FFT bins into one receive symbol, checks bin
// order (ORDERED=1) or duplicates (ORDERED=0), and hands the symbol on through
// a one-deep valid/ready output buffer. Samples are passed through untouched.
// Optional feature macro FRAME_TIMEOUT_EN: when defined, a partial frame is
// dropped after TIMEOUT_CYC consecutive COLLECT cycles without an accepted bin;
// when undefined, frame_timeout is tied low and a partial frame waits forever.
module rx_frame_collect #(
  parameter int DW          = 20,
  parameter int NBIN        = 8,
  parameter int ORDERED     = 1,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rstn,
  rx_frame_collect_if.slave bus
);
  localparam int IW = (NBIN > 1) ? $clog2(NBIN) : 1;
  localparam int CW = $clog2(NBIN + 1);

  typedef enum logic {IDLE, COLLECT} state_t;
  typedef logic [NBIN-1:0][DW-1:0] sym_t;

  state_t          state, state_n;
  logic [NBIN-1:0] mask, base_mask, hit_mask;
  sym_t            work_real, work_imag, merged_real, merged_imag;
  sym_t            out_real, out_imag;
  logic            out_valid;
  logic [15:0]     out_count;
  logic            err_order_q, err_dup_q, overrun_q, timeout_q;
  logic            any_hot, multi_hot;
  logic [IW-1:0]   bin_idx;
  logic [CW-1:0]   fill;
  logic            accept, discard, set_order, set_dup;
  logic            complete, load, overrun, timeout_hit;

  if (NBIN < 2 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("rx_frame_collect: NBIN must be >= 2 and TIMEOUT_CYC >= 1");
  end

  // State register: IDLE while no bins are held, COLLECT while a partial frame is pending
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  // Strobe decode: single/multi-hot detection, bin index and number of bins already held
  always_comb begin
    any_hot   = |bus.Rx_tvalid;
    multi_hot = (bus.Rx_tvalid & (bus.Rx_tvalid - NBIN'(1))) != '0;
    bin_idx   = '0;
    for (int b = 0; b < NBIN; b++) begin
      if (bus.Rx_tvalid[b]) bin_idx = IW'(b);
    end
    fill = '0;
    for (int b = 0; b < NBIN; b++) begin
      fill = fill + CW'(mask[b]);
    end
  end

  // Control decode: accept/discard a bin, raise errors, detect completion and buffer hand-off
  always_comb begin
    accept    = 1'b0;
    discard   = 1'b0;
    set_order = 1'b0;
    set_dup   = 1'b0;
    if (any_hot) begin
      if (multi_hot) begin
        set_order = 1'b1;
        discard   = 1'b1;
      end else if (ORDERED != 0) begin
        if (fill == CW'(bin_idx)) begin
          accept = 1'b1;
        end else if (bin_idx == '0) begin
          set_order = 1'b1;
          discard   = 1'b1;
          accept    = 1'b1;
        end else begin
          set_order = 1'b1;
          discard   = 1'b1;
        end
      end else begin
        accept  = 1'b1;
        set_dup = mask[bin_idx];
      end
    end
    hit_mask  = accept ? (NBIN'(1) << bin_idx) : '0;
    base_mask = discard ? '0 : mask;
    complete  = accept && ((base_mask | hit_mask) == '1);
    load      = complete && (!out_valid || bus.frame_ready);
    overrun   = complete && out_valid && !bus.frame_ready;
  end

  // Next state: completion, timeout or discard return to IDLE; an accepted bin keeps collecting
  always_comb begin
    state_n = state;
    if (complete || timeout_hit) state_n = IDLE;
    else if (accept)             state_n = COLLECT;
    else if (discard)            state_n = IDLE;
  end

  // Working symbol with this cycle's bin merged in, so completion can load it directly
  always_comb begin
    merged_real = work_real;
    merged_imag = work_imag;
    if (accept) begin
      merged_real[bin_idx] = bus.receive_sig_real[bin_idx];
      merged_imag[bin_idx] = bus.receive_sig_imag[bin_idx];
    end
  end

  // Working buffer and received-bin mask
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      work_real <= '0;
      work_imag <= '0;
      mask      <= '0;
    end else begin
      work_real <= merged_real;
      work_imag <= merged_imag;
      mask      <= (complete || timeout_hit) ? '0 : (base_mask | hit_mask);
    end
  end

  // Output buffer, symbol counter and registered one-cycle error pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_real    <= '0;
      out_imag    <= '0;
      out_valid   <= 1'b0;
      out_count   <= '0;
      err_order_q <= 1'b0;
      err_dup_q   <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      if (load) begin
        out_real  <= merged_real;
        out_imag  <= merged_imag;
        out_valid <= 1'b1;
        out_count <= out_count + 16'd1;
      end else if (out_valid && bus.frame_ready) begin
        out_valid <= 1'b0;
      end
      err_order_q <= set_order;
      err_dup_q   <= set_dup;
      overrun_q   <= overrun;
      timeout_q   <= timeout_hit;
    end
  end

`ifdef FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] idle_cnt;
  logic          idle_tick;

  assign idle_tick   = (state == COLLECT) && !accept && !discard;
  assign timeout_hit = idle_tick && (idle_cnt == TW'(TIMEOUT_CYC - 1));

  // Count consecutive COLLECT cycles without an accepted bin
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) idle_cnt <= '0;
    else       idle_cnt <= (idle_tick && !timeout_hit) ? idle_cnt + TW'(1) : '0;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign bus.frame_real    = out_real;
  assign bus.frame_imag    = out_imag;
  assign bus.frame_valid   = out_valid;
  assign bus.frame_count   = out_count;
  assign bus.err_order     = err_order_q;
  assign bus.err_dup       = err_dup_q;
  assign bus.frame_overrun = overrun_q;
  assign bus.frame_timeout = timeout_q;
endmodule

// File: tb/tb_rx_frame_collect.sv
// tb_rx_frame_collect: drives an ORDERED=1 and an ORDERED=0 collector with the
// same bin stream and compares both against a behavioural frame model.
module tb_rx_frame_collect;
  localparam int DW = 20;
  localparam int NBIN = 8;
  localparam int TIMEOUT_CYC = 64;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [NBIN-1:0][DW-1:0] in_re, in_im;
  logic [NBIN-1:0]         in_strobe;
  logic                    in_ready;

  rx_frame_collect_if #(.DW(DW), .NBIN(NBIN)) bus_o ();
  rx_frame_collect_if #(.DW(DW), .NBIN(NBIN)) bus_a ();

  assign bus_o.receive_sig_real = in_re;
  assign bus_o.receive_sig_imag = in_im;
  assign bus_o.Rx_tvalid        = in_strobe;
  assign bus_o.frame_ready      = in_ready;
  assign bus_a.receive_sig_real = in_re;
  assign bus_a.receive_sig_imag = in_im;
  assign bus_a.Rx_tvalid        = in_strobe;
  assign bus_a.frame_ready      = in_ready;

  rx_frame_collect #(.DW(DW), .NBIN(NBIN), .ORDERED(1), .TIMEOUT_CYC(TIMEOUT_CYC)) u_ord (
    .clk(clk), .rstn(rstn), .bus(bus_o));
  rx_frame_collect #(.DW(DW), .NBIN(NBIN), .ORDERED(0), .TIMEOUT_CYC(TIMEOUT_CYC)) u_any (
    .clk(clk), .rstn(rstn), .bus(bus_a));

  // Observed outputs per instance: 0 = ordered, 1 = any order
  logic [NBIN-1:0][DW-1:0] obs_re [2];
  logic [NBIN-1:0][DW-1:0] obs_im [2];
  logic [15:0]             obs_cnt [2];
  logic [4:0]              obs_st [2];
  assign obs_re[0]  = bus_o.frame_real;
  assign obs_im[0]  = bus_o.frame_imag;
  assign obs_cnt[0] = bus_o.frame_count;
  assign obs_st[0]  = {bus_o.frame_valid, bus_o.err_order, bus_o.err_dup, bus_o.frame_overrun, bus_o.frame_timeout};
  assign obs_re[1]  = bus_a.frame_real;
  assign obs_im[1]  = bus_a.frame_imag;
  assign obs_cnt[1] = bus_a.frame_count;
  assign obs_st[1]  = {bus_a.frame_valid, bus_a.err_order, bus_a.err_dup, bus_a.frame_overrun, bus_a.frame_timeout};

  int checks = 0;
  int passed = 0;

  // Behavioural model: set of received bins, slot values, one output buffer
  bit                      m_got [2][NBIN];
  logic [DW-1:0]           m_slot_re [2][NBIN];
  logic [DW-1:0]           m_slot_im [2][NBIN];
  logic [NBIN-1:0][DW-1:0] m_out_re [2];
  logic [NBIN-1:0][DW-1:0] m_out_im [2];
  bit                      m_valid [2], m_eord [2], m_edup [2], m_ovr [2], m_tmo [2];
  logic [15:0]             m_count [2];
  int                      m_idle [2];

  function automatic int got_count(input int i);
    int n = 0;
    for (int b = 0; b < NBIN; b++) n += int'(m_got[i][b]);
    return n;
  endfunction

  function automatic logic [4:0] exp_st(input int i);
    return {m_valid[i], m_eord[i], m_edup[i], m_ovr[i], m_tmo[i]};
  endfunction

  task automatic model_forget(input int i);
    for (int b = 0; b < NBIN; b++) m_got[i][b] = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      model_forget(i);
      for (int b = 0; b < NBIN; b++) begin
        m_slot_re[i][b] = '0;
        m_slot_im[i][b] = '0;
      end
      m_out_re[i] = '0; m_out_im[i] = '0; m_count[i] = '0; m_idle[i] = 0;
      m_valid[i] = 0; m_eord[i] = 0; m_edup[i] = 0; m_ovr[i] = 0; m_tmo[i] = 0;
    end
  endtask

  // Advance instance i by one cycle of the current inputs
  task automatic model_step(input int i);
    int  nhot = 0;
    int  k = 0;
    bit  acc = 0;
    bit  loaded = 0;
    bit  consume;
    consume = m_valid[i] && in_ready;
    m_eord[i] = 0; m_edup[i] = 0; m_ovr[i] = 0; m_tmo[i] = 0;
    for (int b = 0; b < NBIN; b++) if (in_strobe[b]) begin nhot++; k = b; end
    if (nhot > 1) begin
      m_eord[i] = 1; model_forget(i);
    end else if (nhot == 1) begin
      if (i == 0) begin
        if (k == got_count(i)) acc = 1;
        else if (k == 0) begin m_eord[i] = 1; model_forget(i); acc = 1; end
        else begin m_eord[i] = 1; model_forget(i); end
      end else begin
        if (m_got[i][k]) m_edup[i] = 1;
        acc = 1;
      end
    end
    if (acc) begin
      m_slot_re[i][k] = in_re[k];
      m_slot_im[i][k] = in_im[k];
      m_got[i][k] = 1;
      if (got_count(i) == NBIN) begin
        model_forget(i);
        if (m_valid[i] && !in_ready) m_ovr[i] = 1;
        else begin
          for (int b = 0; b < NBIN; b++) begin
            m_out_re[i][b] = m_slot_re[i][b];
            m_out_im[i][b] = m_slot_im[i][b];
          end
          m_count[i] = m_count[i] + 16'd1;
          loaded = 1;
        end
      end
    end
    if (loaded) m_valid[i] = 1;
    else if (consume) m_valid[i] = 0;
    if (got_count(i) != 0 && !acc) begin
      m_idle[i]++;
`ifdef FRAME_TIMEOUT_EN
      if (m_idle[i] == TIMEOUT_CYC) begin m_tmo[i] = 1; model_forget(i); m_idle[i] = 0; end
`endif
    end else m_idle[i] = 0;
  endtask

  task automatic cycle(input logic [NBIN-1:0] strobe);
    in_strobe = strobe;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    in_strobe = '0;
  endtask

  task automatic send(input int k, input logic [DW-1:0] re, input logic [DW-1:0] im);
    in_re[k] = re;
    in_im[k] = im;
    cycle(NBIN'(1) << k);
  endtask

  task automatic send_rand(input int k);
    send(k, DW'($urandom), DW'($urandom));
  endtask

  task automatic do_reset();
    rstn = 1'b0; in_strobe = '0; in_ready = 1'b1; in_re = '0; in_im = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      checks++; if ({obs_st[i], obs_cnt[i]} !== '0) $display("[TB] FAIL reset_status[%0d]: got %h need 0", i, {obs_st[i], obs_cnt[i]}); else passed++;
      checks++; if ({obs_re[i], obs_im[i]} !== '0) $display("[TB] FAIL reset_data[%0d]: got %h need 0", i, {obs_re[i], obs_im[i]}); else passed++;
    end
  endtask

  task automatic test_basic();
    logic [NBIN-1:0][DW-1:0] exp_re, exp_im;
    do_reset();
    for (int k = 0; k < NBIN; k++) begin
      exp_re[k] = DW'(k + 1);
      exp_im[k] = DW'(-(k + 1));
      send(k, exp_re[k], exp_im[k]);
      if (k == NBIN - 2) begin
        checks++; if (obs_st[0][4] !== 1'b0) $display("[TB] FAIL basic_early_valid: got %b need 0", obs_st[0][4]); else passed++;
      end
    end
    for (int i = 0; i < 2; i++) begin
      checks++; if (obs_st[i] !== 5'b10000 || obs_cnt[i] !== 16'd1) $display("[TB] FAIL basic_status[%0d]: got %b/%0d need 10000/1", i, obs_st[i], obs_cnt[i]); else passed++;
      checks++; if (obs_re[i] !== exp_re || obs_im[i] !== exp_im) $display("[TB] FAIL basic_data[%0d]: got %h/%h need %h/%h", i, obs_re[i], obs_im[i], exp_re, exp_im); else passed++;
    end
    cycle('0);
    checks++; if (obs_st[0][4] !== 1'b0) $display("[TB] FAIL basic_handshake: got %b need 0", obs_st[0][4]); else passed++;
  endtask

  task automatic test_order();
    do_reset();
    send_rand(0); send_rand(1); send_rand(3);
    checks++; if (obs_st[0] !== 5'b01000) $display("[TB] FAIL order_err: got %b need 01000", obs_st[0]); else passed++;
    checks++; if (obs_st[1] !== exp_st(1)) $display("[TB] FAIL order_any: got %b need %b", obs_st[1], exp_st(1)); else passed++;
    for (int k = 0; k < NBIN; k++) send_rand(k);
    checks++; if (obs_st[0] !== 5'b10000 || obs_cnt[0] !== 16'd1) $display("[TB] FAIL order_frame: got %b/%0d need 10000/1", obs_st[0], obs_cnt[0]); else passed++;
    for (int i = 0; i < 2; i++) begin
      checks++; if (obs_re[i] !== m_out_re[i] || obs_cnt[i] !== m_count[i]) $display("[TB] FAIL order_data[%0d]: got %h/%0d need %h/%0d", i, obs_re[i], obs_cnt[i], m_out_re[i], m_count[i]); else passed++;
    end
  endtask

  task automatic test_dup();
    int seq [9] = '{7, 6, 5, 4, 4, 3, 2, 1, 0};
    int dups = 0;
    do_reset();
    for (int s = 0; s < 9; s++) begin
      if (s == 3) send(4, 20'h7FFFF, 20'h00001);
      else if (s == 4) send(4, 20'h80000, 20'h00002);
      else send_rand(seq[s]);
      dups += int'(obs_st[1][2]);
    end
    checks++; if (dups !== 1) $display("[TB] FAIL dup_count: got %0d need 1", dups); else passed++;
    checks++; if (obs_re[1][4] !== 20'h80000) $display("[TB] FAIL dup_slot4: got %h need 80000", obs_re[1][4]); else passed++;
    for (int i = 0; i < 2; i++) begin
      checks++; if ({obs_st[i], obs_cnt[i], obs_re[i], obs_im[i]} !== {exp_st(i), m_count[i], m_out_re[i], m_out_im[i]}) $display("[TB] FAIL dup_model[%0d]: got %b/%0d need %b/%0d", i, obs_st[i], obs_cnt[i], exp_st(i), m_count[i]); else passed++;
    end
  endtask

  task automatic test_overrun();
    logic [NBIN-1:0][DW-1:0] held;
    int changed = 0;
    do_reset();
    in_ready = 1'b0;
    for (int k = 0; k < NBIN; k++) send_rand(k);
    held = m_out_re[0];
    for (int k = 0; k < NBIN; k++) begin
      send_rand(k);
      if (obs_re[0] !== held) changed++;
    end
    checks++; if (changed !== 0) $display("[TB] FAIL overrun_stable: got %0d changes need 0", changed); else passed++;
    for (int i = 0; i < 2; i++) begin
      checks++; if (obs_st[i] !== 5'b10010 || obs_cnt[i] !== 16'd1) $display("[TB] FAIL overrun_pulse[%0d]: got %b/%0d need 10010/1", i, obs_st[i], obs_cnt[i]); else passed++;
    end
    in_ready = 1'b1;
    cycle('0);
    checks++; if (obs_st[0] !== 5'b00000 || obs_re[0] !== held) $display("[TB] FAIL overrun_release: got %b need 00000", obs_st[0]); else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_ready = 1'b0;
    for (int k = 0; k < NBIN; k++) send_rand(k);
    for (int k = 0; k < NBIN - 1; k++) send_rand(k);
    in_ready = 1'b1;
    send_rand(NBIN - 1);
    for (int i = 0; i < 2; i++) begin
      checks++; if (obs_st[i] !== 5'b10000 || obs_cnt[i] !== 16'd2) $display("[TB] FAIL b2b_status[%0d]: got %b/%0d need 10000/2", i, obs_st[i], obs_cnt[i]); else passed++;
      checks++; if (obs_re[i] !== m_out_re[i] || obs_im[i] !== m_out_im[i]) $display("[TB] FAIL b2b_data[%0d]: got %h need %h", i, obs_re[i], m_out_re[i]); else passed++;
    end
  endtask

  task automatic test_multihot();
    do_reset();
    send_rand(0); send_rand(1); send_rand(2);
    cycle(8'b0000_0011);
    for (int i = 0; i < 2; i++) begin
      checks++; if (obs_st[i] !== 5'b01000) $display("[TB] FAIL multihot_err[%0d]: got %b need 01000", i, obs_st[i]); else passed++;
    end
    for (int k = 0; k < NBIN; k++) send_rand(k);
    for (int i = 0; i < 2; i++) begin
      checks++; if (obs_cnt[i] !== 16'd1 || obs_re[i] !== m_out_re[i]) $display("[TB] FAIL multihot_frame[%0d]: got %0d/%h need 1/%h", i, obs_cnt[i], obs_re[i], m_out_re[i]); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_ready = 1'b0;
    for (int k = 0; k < NBIN; k++) send_rand(k);
    for (int k = 0; k < 4; k++) send_rand(k);
    rstn = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++; if ({obs_st[i], obs_cnt[i], obs_re[i], obs_im[i]} !== '0) $display("[TB] FAIL reset_mid[%0d]: got %b/%0d need 0/0", i, obs_st[i], obs_cnt[i]); else passed++;
    end
    model_reset();
    @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic test_timeout();
    int early = 0;
    do_reset();
    send_rand(0); send_rand(1); send_rand(2);
`ifdef FRAME_TIMEOUT_EN
    repeat (TIMEOUT_CYC - 1) begin
      cycle('0);
      early += int'(obs_st[0][0]);
    end
    checks++; if (early !== 0) $display("[TB] FAIL timeout_early: got %0d need 0", early); else passed++;
    cycle('0);
    for (int i = 0; i < 2; i++) begin
      checks++; if (obs_st[i][0] !== 1'b1) $display("[TB] FAIL timeout_pulse[%0d]: got %b need 1", i, obs_st[i][0]); else passed++;
    end
    for (int k = 0; k < NBIN; k++) send_rand(k);
`else
    repeat (2 * TIMEOUT_CYC) begin
      cycle('0);
      early += int'(obs_st[0][0]) + int'(obs_st[1][0]);
    end
    checks++; if (early !== 0) $display("[TB] FAIL timeout_tied: got %0d need 0", early); else passed++;
    for (int k = 3; k < NBIN; k++) send_rand(k);
`endif
    for (int i = 0; i < 2; i++) begin
      checks++; if (obs_st[i][4] !== 1'b1 || obs_cnt[i] !== 16'd1 || obs_re[i] !== m_out_re[i]) $display("[TB] FAIL timeout_frame[%0d]: got %b/%0d need 1/1", i, obs_st[i][4], obs_cnt[i]); else passed++;
    end
  endtask

  task automatic test_random();
    int r, a, b;
    logic [NBIN-1:0] strobe;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      in_ready = ($urandom_range(0, 99) < 70);
      r = $urandom_range(0, 99);
      strobe = '0;
      if (r < 50) strobe = NBIN'(1) << got_count(0);
      else if (r < 65) strobe = '0;
      else if (r < 85) strobe = NBIN'(1) << $urandom_range(0, NBIN - 1);
      else if (r < 92) strobe = NBIN'(1);
      else begin
        a = $urandom_range(0, NBIN - 1);
        b = (a + 1 + $urandom_range(0, NBIN - 2)) % NBIN;
        strobe = (NBIN'(1) << a) | (NBIN'(1) << b);
      end
      for (int k = 0; k < NBIN; k++) if (strobe[k]) begin in_re[k] = DW'($urandom); in_im[k] = DW'($urandom); end
      cycle(strobe);
      for (int i = 0; i < 2; i++) begin
        checks++; if ({obs_st[i], obs_cnt[i]} !== {exp_st(i), m_count[i]}) $display("[TB] FAIL rand_status[%0d] cyc %0d: got %b/%0d need %b/%0d", i, n, obs_st[i], obs_cnt[i], exp_st(i), m_count[i]); else passed++;
        checks++; if (obs_re[i] !== m_out_re[i] || obs_im[i] !== m_out_im[i]) $display("[TB] FAIL rand_data[%0d] cyc %0d: got %h need %h", i, n, obs_re[i], m_out_re[i]); else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_order();
    test_dup();
    test_overrun();
    test_back_to_back();
    test_multihot();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
